pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//   Parametrised program-counter unit for the mos6502 core. Successor to the basic
//   HOLD/INC/ABS counter. Adds signed relative branches with page-cross flagging.
//   Adds a two-cycle vector fetch (reset, and IRQ/NMI/BRK via VEC mode) that reads
//   the new PC little-endian from memory. Sits between the control FSM (drives ps)
//   and the address mux (consumes pc_out, vec_addr).
// PARAMETERS
//   ADDR_W   16        PC / address width; must equal 2*DATA_W
//   DATA_W   8         memory data width (one vector byte)
//   OFF_W    8         signed branch offset width, sign-extended to ADDR_W
//   RST_VEC  16'hFFFC  vector base fetched after reset
// PORTS
//   clk         in   1        system clock, all state on rising edge
//   rst_n       in   1        synchronous reset, active low
//   ps          in   3        op: 0 HOLD, 1 INC, 2 ABS, 3 REL, 4 VEC, 5-7 reserved
//   pc_in       in   ADDR_W   absolute target (ABS)
//   offset      in   OFF_W    signed two's-complement branch offset (REL)
//   vec_base    in   ADDR_W   vector low-byte address (VEC)
//   data_in     in   DATA_W   memory read data, valid in the cycle vec_rd=1
//   pc_out      out  ADDR_W   registered program counter
//   vec_addr    out  ADDR_W   vector byte address being read
//   vec_rd      out  1        vector read in progress this cycle
//   busy        out  1        vector fetch active; ps is ignored
//   page_cross  out  1        registered; last REL crossed a 256-byte page
//   err         out  1        sticky: reserved ps code seen in RUN
// BEHAVIOUR
//   - FSM states: RUN, V_LO, V_HI. busy = vec_rd = (state != RUN).
//   - vec_addr: V_LO -> vbase. V_HI -> vbase+1, wrapping mod 2^ADDR_W. RUN -> vbase.
//   - Reset (rst_n=0 at edge) sets: state=V_LO, vbase=RST_VEC, pc_out=0,
//     page_cross=0, err=0, lo byte=0. Reset has priority over all else.
//     Reset in any state, including mid-fetch, abandons that fetch.
//     Fetch restarts at RST_VEC after release.
//   - V_LO edge: lo <= data_in, state -> V_HI.
//   - V_HI edge: pc_out <= {data_in, lo}, state -> RUN.
//   - ps is ignored in both vector states. page_cross is 0 in both vector states.
//   - RUN, per edge:
//       HOLD: pc_out unchanged.
//       INC: pc_out+1, wraps FFFF->0000.
//       ABS: pc_in.
//       REL: pc_out + sext(offset), wraps mod 2^ADDR_W.
//         page_cross <= (new[ADDR_W-1:8] != old[ADDR_W-1:8]).
//       VEC: vbase <= vec_base, state -> V_LO, pc_out holds.
//       Reserved codes: pc_out holds, err <= 1.
//     page_cross is cleared on every RUN edge that is not REL.
//     err stays set until reset.
//   - Latency:
//       HOLD/INC/ABS/REL: result visible after 1 edge.
//       VEC: new PC visible 3 edges after the edge that samples ps=VEC.
//       Reset: first PC visible 2 edges after the first edge with rst_n=1.
// TESTING
//   1 rst_n=0 for 2 clk, release; mem[FFFC]=34, mem[FFFD]=12.
//     -> vec_addr FFFC then FFFD; pc_out=1234, busy=0 after 2nd edge.
//   2 ABS pc_in=FFFF, then INC -> pc_out FFFF then 0000; page_cross=0; err=0.
//   3 pc=12F0, REL off=20 -> pc 1310, page_cross=1.
//     Then REL off=F0 -> pc 1300, page_cross=0.
//     Then HOLD -> page_cross=0.
//   4 pc=1300, VEC vec_base=FFFE; mem FFFE=00, FFFF=80; hold ps=INC throughout.
//     -> pc 1300 for 2 edges, then 8000; ps ignored while busy.
//   5 RUN, ps=7 -> err=1, pc holds; then INC -> pc+1, err stays 1.
//     Then rst_n=0 -> err=0.
//   6 VEC vec_base=FFFA, assert rst_n=0 in V_HI.
//     -> pc_out=0, fetch restarts at FFFC, pc from FFFC/FFFD.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter with INC/ABS/REL updates and a two-cycle little-endian vector fetch
module pc_unit #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int OFF_W = 8,
   parameter logic [ADDR_W-1:0] RST_VEC = 16'hFFFC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        ps,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [OFF_W-1:0]  offset,
   input  logic [ADDR_W-1:0] vec_base,
   input  logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] vec_addr,
   output logic              vec_rd,
   output logic              busy,
   output logic              page_cross,
   output logic              err
);
   localparam logic [1:0] RUN = 2'd0, V_LO = 2'd1, V_HI = 2'd2;
   localparam logic [2:0] INC = 3'd1, ABS = 3'd2, REL = 3'd3, VEC = 3'd4;
   logic [1:0] state;
   logic [ADDR_W-1:0] vbase, rel_pc, next_pc;
   logic [DATA_W-1:0] lo;
   always_comb begin
      rel_pc = pc_out + {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
      next_pc = ps == INC ? pc_out + ADDR_W'(1) : ps == ABS ? pc_in : ps == REL ? rel_pc : pc_out;
      vec_addr = state == V_HI ? vbase + ADDR_W'(1) : vbase;
      busy = state != RUN;
      vec_rd = busy;
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= V_LO;
         vbase <= RST_VEC;
         pc_out <= '0;
         page_cross <= 1'b0;
         err <= 1'b0;
         lo <= '0;
      end else if (state == V_LO) begin
         lo <= data_in;
         state <= V_HI;
      end else if (state == V_HI) begin
         pc_out <= {data_in, lo};
         state <= RUN;
      end else begin
         pc_out <= next_pc;
         page_cross <= ps == REL && rel_pc[ADDR_W-1:8] != pc_out[ADDR_W-1:8];
         err <= err | (ps > VEC);
         if (ps == VEC) begin
            vbase <= vec_base;
            state <= V_LO;
         end
      end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: vector-table and hand-sequenced checks of pc_unit through an expected-value queue
module tb_pc_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] ps = '0;
   logic [15:0] pc_in = '0, vec_base = '0;
   logic [7:0] offset = '0, data_in;
   logic [15:0] pc_out, vec_addr;
   logic vec_rd, busy, page_cross, err;
   logic [7:0] mem [0:65535];
   int n_cmp = 0, n_bad = 0;
   typedef struct {
      string nm;
      logic rn;
      logic [2:0] ps;
      logic [15:0] pin;
      logic [7:0] off;
      logic [15:0] vb;
      logic [15:0] pc;
      logic bsy;
      logic pcx;
      logic er;
      logic [15:0] va;
   } vec_t;
   vec_t q[$];
   vec_t tbl[$];
   pc_unit dut (
      .clk(clk), .rst_n(rst_n), .ps(ps), .pc_in(pc_in), .offset(offset),
      .vec_base(vec_base), .data_in(data_in), .pc_out(pc_out), .vec_addr(vec_addr),
      .vec_rd(vec_rd), .busy(busy), .page_cross(page_cross), .err(err)
   );
   always #5 clk = ~clk;
   assign data_in = vec_rd ? mem[vec_addr] : 8'h00;
   function automatic vec_t mk(string nm, logic rn, logic [2:0] p, logic [15:0] pin, logic [7:0] off,
                               logic [15:0] vb, logic [15:0] pc, logic bsy, logic pcx, logic er, logic [15:0] va);
      vec_t v;
      v.nm = nm; v.rn = rn; v.ps = p; v.pin = pin; v.off = off; v.vb = vb;
      v.pc = pc; v.bsy = bsy; v.pcx = pcx; v.er = er; v.va = va;
      return v;
   endfunction
   task automatic chk(string nm, string f, logic [15:0] act, logic [15:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s.%s: got %h want %h", nm, f, act, want);
      end
   endtask
   task automatic drive(vec_t v);
      rst_n = v.rn; ps = v.ps; pc_in = v.pin; offset = v.off; vec_base = v.vb;
      q.push_back(v);
      @(posedge clk);
      #2;
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         vec_t e;
         e = q.pop_front();
         chk(e.nm, "pc_out", pc_out, e.pc);
         chk(e.nm, "busy", {15'd0, busy}, {15'd0, e.bsy});
         chk(e.nm, "vec_rd", {15'd0, vec_rd}, {15'd0, e.bsy});
         chk(e.nm, "page_cross", {15'd0, page_cross}, {15'd0, e.pcx});
         chk(e.nm, "err", {15'd0, err}, {15'd0, e.er});
         chk(e.nm, "vec_addr", vec_addr, e.va);
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
      mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
      mem[16'h0000] = 8'hAB;
      mem[16'hFFFA] = 8'h11; mem[16'hFFFB] = 8'h22;
      tbl.push_back(mk("rst0", 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'hFFFC));
      tbl.push_back(mk("rst1", 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'hFFFC));
      tbl.push_back(mk("rst_vlo", 1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'hFFFD));
      tbl.push_back(mk("rst_vhi", 1, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 16'hFFFC));
      tbl.push_back(mk("abs_ffff", 1, 2, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 0, 16'hFFFC));
      tbl.push_back(mk("inc_wrap", 1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'hFFFC));
      tbl.push_back(mk("abs_12f0", 1, 2, 16'h12F0, 0, 0, 16'h12F0, 0, 0, 0, 16'hFFFC));
      tbl.push_back(mk("rel_fwd_x", 1, 3, 0, 8'h20, 0, 16'h1310, 0, 1, 0, 16'hFFFC));
      tbl.push_back(mk("rel_back", 1, 3, 0, 8'hF0, 0, 16'h1300, 0, 0, 0, 16'hFFFC));
      tbl.push_back(mk("hold", 1, 0, 0, 0, 0, 16'h1300, 0, 0, 0, 16'hFFFC));
      tbl.push_back(mk("rel_back_x", 1, 3, 0, 8'hFF, 0, 16'h12FF, 0, 1, 0, 16'hFFFC));
      tbl.push_back(mk("hold_clr", 1, 0, 0, 0, 0, 16'h12FF, 0, 0, 0, 16'hFFFC));
      tbl.push_back(mk("abs_fff0", 1, 2, 16'hFFF0, 0, 0, 16'hFFF0, 0, 0, 0, 16'hFFFC));
      tbl.push_back(mk("rel_wrap", 1, 3, 0, 8'h20, 0, 16'h0010, 0, 1, 0, 16'hFFFC));
      tbl.push_back(mk("abs_clr", 1, 2, 16'h1300, 0, 0, 16'h1300, 0, 0, 0, 16'hFFFC));
      for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
      drive(mk("vec_go", 1, 4, 0, 0, 16'hFFFE, 16'h1300, 1, 0, 0, 16'hFFFE));
      drive(mk("vec_lo", 1, 1, 0, 0, 0, 16'h1300, 1, 0, 0, 16'hFFFF));
      drive(mk("vec_hi", 1, 1, 0, 0, 0, 16'h8000, 0, 0, 0, 16'hFFFE));
      drive(mk("vec_inc", 1, 1, 0, 0, 0, 16'h8001, 0, 0, 0, 16'hFFFE));
      drive(mk("vw_go", 1, 4, 0, 0, 16'hFFFF, 16'h8001, 1, 0, 0, 16'hFFFF));
      drive(mk("vw_lo", 1, 1, 0, 0, 0, 16'h8001, 1, 0, 0, 16'h0000));
      drive(mk("vw_hi", 1, 1, 0, 0, 0, 16'hAB80, 0, 0, 0, 16'hFFFF));
      drive(mk("res7", 1, 7, 0, 0, 0, 16'hAB80, 0, 0, 1, 16'hFFFF));
      drive(mk("res5", 1, 5, 0, 0, 0, 16'hAB80, 0, 0, 1, 16'hFFFF));
      drive(mk("err_sticky", 1, 1, 0, 0, 0, 16'hAB81, 0, 0, 1, 16'hFFFF));
      drive(mk("err_rst", 0, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'hFFFC));
      drive(mk("err_vlo", 1, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'hFFFD));
      drive(mk("err_vhi", 1, 1, 0, 0, 0, 16'h1234, 0, 0, 0, 16'hFFFC));
      drive(mk("m_abs", 1, 2, 16'h12F0, 0, 0, 16'h12F0, 0, 0, 0, 16'hFFFC));
      drive(mk("m_rel", 1, 3, 0, 8'h20, 0, 16'h1310, 0, 1, 0, 16'hFFFC));
      drive(mk("m_vec", 1, 4, 0, 0, 16'hFFFA, 16'h1310, 1, 0, 0, 16'hFFFA));
      drive(mk("m_lo_ps7", 1, 7, 0, 0, 0, 16'h1310, 1, 0, 0, 16'hFFFB));
      drive(mk("m_rst_vhi", 0, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'hFFFC));
      drive(mk("m_vlo", 1, 4, 0, 0, 0, 16'h0000, 1, 0, 0, 16'hFFFD));
      drive(mk("m_vhi", 1, 4, 0, 0, 0, 16'h1234, 0, 0, 0, 16'hFFFC));
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
